// File: rtl/hs_rx_fifo_slave_pkg.sv
// ----------------------------------------------------------------------------
// hs_pkg : shared types and constants for the hs_rx_fifo_slave receive path.
//   hs_state_t : 4-phase handshake FSM states (IDLE, ACK, HOLD, DROP).
//   CNT_W      : width of the counter that times the ACK state (MIN_ACK <= 15).
// ----------------------------------------------------------------------------
package hs_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK  = 2'd1,
        HOLD = 2'd2,
        DROP = 2'd3
    } hs_state_t;

    localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/hs_rx_fifo_slave_if.sv
// ----------------------------------------------------------------------------
// hs_rx_fifo_slave_if : 4-phase req/ack link between a master and the slave.
//   req     : transfer request (master -> slave)
//   data_in : DW-bit word, valid while req=1 (master -> slave)
//   ack     : acknowledge (slave -> master)
// Modports: master (drives req/data_in), slave (drives ack).
// ----------------------------------------------------------------------------
interface hs_rx_fifo_slave_if #(
    parameter int unsigned DW = 8
);
    logic          req;
    logic [DW-1:0] data_in;
    logic          ack;

    modport master (output req, output data_in, input ack);
    modport slave  (input req, input data_in, output ack);
endinterface

// File: rtl/hs_rx_fifo_slave_fifo.sv
// ----------------------------------------------------------------------------
// hs_sync_fifo : synchronous FIFO with first-word-fall-through read port.
//   clk, rst : clock, synchronous active-high reset (clears pointers/count)
//   push_i   : write din_i (ignored while full)
//   din_i    : write data
//   pop_i    : advance head (ignored while empty)
//   dout_o   : head word, combinational from registered read pointer
//   count_o  : occupancy; full_o / empty_o derived from it
// Push is qualified by the pre-pop count, so a pop at full frees space only
// for the following edge.
// ----------------------------------------------------------------------------
module hs_sync_fifo #(
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [DW-1:0]              din_i,
    input  logic                       pop_i,
    output logic [DW-1:0]              dout_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       empty_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    // Storage needs no reset; contents are don't-care while unoccupied.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/hs_rx_fifo_slave.sv
// ----------------------------------------------------------------------------
// hs_rx_fifo_slave : 4-phase req/ack receive slave feeding a receive FIFO.
//   clk, rst   : clock, synchronous active-high reset
//   link       : slave modport of hs_rx_fifo_slave_if (req, data_in, ack)
//   rd_en      : consumer pop strobe (ignored while empty)
//   rd_data    : FIFO head word, valid while empty=0
//   empty/full : FIFO status; count : occupancy
//   last_byte  : most recently accepted word
//   proto_err  : sticky protocol-error flag
// Build option: define HS_ERR_CHK_EN to enable the protocol checker; without
// it proto_err is tied to 0.
// ----------------------------------------------------------------------------
module hs_rx_fifo_slave
    import hs_pkg::*;
#(
    parameter int unsigned DW      = 8,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned MIN_ACK = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    hs_rx_fifo_slave_if.slave          link,
    input  logic                       rd_en,
    output logic [DW-1:0]              rd_data,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [DW-1:0]              last_byte,
    output logic                       proto_err
);
    hs_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ack_q, ack_d;
    logic [DW-1:0]    last_q;
    logic             push;

    hs_sync_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .din_i   (link.data_in),
        .pop_i   (rd_en),
        .dout_o  (rd_data),
        .count_o (count),
        .full_o  (full),
        .empty_o (empty)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        push    = 1'b0;
        case (state_q)
            IDLE: begin
                if (link.req && !full) begin
                    state_d = ACK;
                    push    = 1'b1;
                    cnt_d   = '0;
                end
            end
            ACK: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(MIN_ACK - 1)) state_d = HOLD;
            end
            HOLD:    if (!link.req) state_d = DROP;
            DROP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // ack is registered from the next state so it tracks ACK/HOLD exactly.
        ack_d = (state_d == ACK) || (state_d == HOLD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
            last_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            if (push) last_q <= link.data_in;
        end
    end

    assign link.ack  = ack_q;
    assign last_byte = last_q;

`ifdef HS_ERR_CHK_EN
    logic perr_q;

    // DROP is only entered with req low, so req seen high in DROP is a rise.
    always_ff @(posedge clk) begin
        if (rst) begin
            perr_q <= 1'b0;
        end else if ((state_q == ACK && !link.req) ||
                     (state_q == DROP && link.req)) begin
            perr_q <= 1'b1;
        end
    end

    assign proto_err = perr_q;
`else
    assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_hs_rx_fifo_slave.sv
module tb_hs_rx_fifo_slave;
    localparam int unsigned DW      = 8;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned MIN_ACK = 2;
    localparam int unsigned CW      = $clog2(DEPTH+1);

    logic          clk = 1'b0;
    logic          rst;
    logic          rd_en;
    logic [DW-1:0] rd_data;
    logic          empty, full;
    logic [CW-1:0] count;
    logic [DW-1:0] last_byte;
    logic          proto_err;

    int errors = 0;
    int checks = 0;

    hs_rx_fifo_slave_if #(.DW(DW)) link ();

    hs_rx_fifo_slave #(.DW(DW), .DEPTH(DEPTH), .MIN_ACK(MIN_ACK)) dut (
        .clk       (clk),
        .rst       (rst),
        .link      (link),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .empty     (empty),
        .full      (full),
        .count     (count),
        .last_byte (last_byte),
        .proto_err (proto_err)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle; inputs are driven and outputs sampled here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compliant 4-phase transfer: hold req through ACK, then drop and wait out DROP.
    task automatic xfer(input logic [DW-1:0] d);
        int n;
        link.req = 1'b1;
        link.data_in = d;
        n = 0;
        do begin tick(); n++; end while (link.ack !== 1'b1 && n < 40);
        checks++;
        if (link.ack !== 1'b1) begin
            errors++;
            $display("FAIL xfer_ack_rise data=%h ack=%b required 1", d, link.ack);
        end
        repeat (MIN_ACK) tick();
        link.req = 1'b0;
        n = 0;
        do begin tick(); n++; end while (link.ack !== 1'b0 && n < 40);
        checks++;
        if (link.ack !== 1'b0) begin
            errors++;
            $display("FAIL xfer_ack_fall data=%h ack=%b required 0", d, link.ack);
        end
        tick();
    endtask

    task automatic pop_expect(input logic [DW-1:0] exp, input string nm);
        checks++;
        if (empty !== 1'b0 || rd_data !== exp) begin
            errors++;
            $display("FAIL %s rd_data=%h empty=%b required %h empty=0", nm, rd_data, empty, exp);
        end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; rd_en = 1'b0; link.req = 1'b0; link.data_in = '0;
        repeat (2) tick();
        checks++;
        if (link.ack !== 1'b0 || count !== '0 || empty !== 1'b1 || full !== 1'b0 ||
            last_byte !== '0 || proto_err !== 1'b0) begin
            errors++;
            $display("FAIL reset ack=%b count=%0d empty=%b full=%b last=%h perr=%b required 0,0,1,0,00,0",
                     link.ack, count, empty, full, last_byte, proto_err);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        logic exp_ack [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        link.req = 1'b1;
        link.data_in = 8'hA5;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 1) link.req = 1'b0;
            checks++;
            if (link.ack !== exp_ack[i]) begin
                errors++;
                $display("FAIL single_ack_cycle%0d ack=%b required %b", i, link.ack, exp_ack[i]);
            end
        end
        checks++;
        if (last_byte !== 8'hA5 || count !== CW'(1) || rd_data !== 8'hA5 || empty !== 1'b0) begin
            errors++;
            $display("FAIL single_data last=%h count=%0d rd_data=%h empty=%b required a5,1,a5,0",
                     last_byte, count, rd_data, empty);
        end
        tick();
        pop_expect(8'hA5, "single_pop");
    endtask

    task automatic test_fill_full();
        for (int i = 1; i <= 4; i++) xfer(DW'(i));
        link.req = 1'b1;
        link.data_in = 8'h05;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (link.ack !== 1'b0 || full !== 1'b1 || count !== CW'(4)) begin
                errors++;
                $display("FAIL full_stall ack=%b full=%b count=%0d required 0,1,4", link.ack, full, count);
            end
        end
        checks++;
        if (rd_data !== 8'h01) begin
            errors++;
            $display("FAIL full_head rd_data=%h required 01", rd_data);
        end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        checks++;
        if (link.ack !== 1'b0 || count !== CW'(3) || rd_data !== 8'h02) begin
            errors++;
            $display("FAIL pop_at_full ack=%b count=%0d rd_data=%h required 0,3,02", link.ack, count, rd_data);
        end
        tick();
        checks++;
        if (link.ack !== 1'b1 || count !== CW'(4) || last_byte !== 8'h05) begin
            errors++;
            $display("FAIL late_accept ack=%b count=%0d last=%h required 1,4,05", link.ack, count, last_byte);
        end
        repeat (MIN_ACK) tick();
        link.req = 1'b0;
        repeat (2) tick();
        for (int i = 2; i <= 5; i++) pop_expect(DW'(i), "full_drain");
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 10; i++) begin
            xfer(DW'(8'h10 + i));
            checks++;
            if (count !== CW'(1)) begin
                errors++;
                $display("FAIL wrap_count idx=%0d count=%0d required 1", i, count);
            end
            pop_expect(DW'(8'h10 + i), "wrap_pop");
        end
        checks++;
        if (empty !== 1'b1 || count !== '0) begin
            errors++;
            $display("FAIL wrap_empty empty=%b count=%0d required 1,0", empty, count);
        end
    endtask

    task automatic test_push_pop();
        xfer(8'h30);
        xfer(8'h31);
        link.req = 1'b1;
        link.data_in = 8'h32;
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        checks++;
        if (count !== CW'(2) || rd_data !== 8'h31 || link.ack !== 1'b1) begin
            errors++;
            $display("FAIL push_pop count=%0d rd_data=%h ack=%b required 2,31,1", count, rd_data, link.ack);
        end
        repeat (MIN_ACK) tick();
        link.req = 1'b0;
        repeat (2) tick();
        pop_expect(8'h31, "push_pop_drain");
        pop_expect(8'h32, "push_pop_drain");
    endtask

    task automatic test_reset_mid();
        link.req = 1'b1;
        link.data_in = 8'h40;
        repeat (1 + MIN_ACK) tick();
        rst = 1'b1;
        tick();
        checks++;
        if (link.ack !== 1'b0 || count !== '0 || empty !== 1'b1 || last_byte !== '0) begin
            errors++;
            $display("FAIL reset_mid ack=%b count=%0d empty=%b last=%h required 0,0,1,00",
                     link.ack, count, empty, last_byte);
        end
        rst = 1'b0;
        link.data_in = 8'h41;
        tick();
        checks++;
        if (link.ack !== 1'b1 || count !== CW'(1) || rd_data !== 8'h41 || last_byte !== 8'h41) begin
            errors++;
            $display("FAIL reset_reaccept ack=%b count=%0d rd_data=%h last=%h required 1,1,41,41",
                     link.ack, count, rd_data, last_byte);
        end
        repeat (MIN_ACK) tick();
        link.req = 1'b0;
        repeat (2) tick();
        pop_expect(8'h41, "reset_drain");
    endtask

    task automatic test_proto_err();
        logic exp_ack [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic exp_perr;
`ifdef HS_ERR_CHK_EN
        exp_perr = 1'b1;
`else
        exp_perr = 1'b0;
`endif
        link.req = 1'b1;
        link.data_in = 8'h50;
        tick();
        link.req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (link.ack !== exp_ack[i] || proto_err !== exp_perr) begin
                errors++;
                $display("FAIL proto_err_seq%0d ack=%b perr=%b required %b,%b",
                         i, link.ack, proto_err, exp_ack[i], exp_perr);
            end
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (proto_err !== 1'b0) begin
            errors++;
            $display("FAIL proto_err_clear perr=%b required 0", proto_err);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_full();
        test_wrap();
        test_push_pop();
        test_reset_mid();
        test_proto_err();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation exceeded 200000 time units");
        $fatal(1);
    end
endmodule

// File: doc/hs_rx_fifo_slave.md
Name: hs_rx_fifo_slave

Overview:
- Parametrised 4-phase req/ack receive slave with an internal receive FIFO.
- Each handshake latches one DW-bit word into a DEPTH-entry FIFO and returns ack for at least MIN_ACK cycles.
- When the FIFO is full, ack is withheld, which back-pressures the master.
- Sits between the link master and the local consumer, which drains the FIFO through a first-word-fall-through read port.

Parameters:
- DW, 8, width of data_in and rd_data.
- DEPTH, 4, number of FIFO entries. Must be a power of 2 and at least 2.
- MIN_ACK, 2, number of cycles spent in the ACK state before ack may drop. Range 1..15.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous reset, active-high.
- req  in  1  transfer request from the master.
- data_in  in  DW  master data; valid while req=1.
- ack  out  1  handshake acknowledge to the master; registered.
- rd_en  in  1  consumer pop strobe.
- rd_data  out  DW  FIFO head word; valid while empty=0.
- empty  out  1  FIFO has no entries.
- full  out  1  FIFO holds DEPTH entries.
- count  out  $clog2(DEPTH+1)  current occupancy.
- last_byte  out  DW  most recently accepted word.
- proto_err  out  1  sticky protocol-error flag. Active only when HS_ERR_CHK_EN is defined.

Behaviour:
- Reset values (rst=1 at a clock edge):
  - state=IDLE, ack=0, count=0, empty=1, full=0, last_byte=0, proto_err=0.
  - FIFO pointers are cleared; FIFO contents are don't-care.
- Reset mid-handshake: ack falls at that edge and the word in flight is not kept.
  - A req still high after reset is treated as a new transfer.
- ack is registered and equals 1 exactly when state is ACK or HOLD.
- States and transitions:
  - IDLE: when req=1 and full=0, go to ACK.
    - At the same edge: push data_in, update last_byte, clear the cycle counter.
    - If req=1 and full=1, stay in IDLE with ack=0 (stall) and push nothing.
  - ACK: the counter increments each cycle.
    - After exactly MIN_ACK cycles in ACK, go to HOLD regardless of req.
  - HOLD: stay while req=1; go to DROP when req=0.
  - DROP: ack=0 for one cycle, req is ignored, then go to IDLE.
  - Any illegal state encoding returns to IDLE.
- Latency:
  - If req is sampled high in IDLE at edge N, ack=1 and empty=0 from edge N onward.
  - Minimum ack-high time is MIN_ACK+1 cycles.
  - Minimum time between two accepted words is MIN_ACK+3 cycles.
- FIFO:
  - rd_data = mem[rd_ptr], combinational from the registered pointer.
  - rd_en with empty=1 is ignored; no underflow and no pointer move.
  - Pointers are $clog2(DEPTH) bits and wrap naturally.
  - count is incremented or decremented per edge; full = (count==DEPTH), empty = (count==0).
  - Push and pop at the same edge (count between 1 and DEPTH-1): both occur and count is unchanged.
  - Push is evaluated against count before the pop. So rd_en at full does not permit a push on the same edge; the transfer is accepted at the next edge.
- data_in is sampled only on the accepting IDLE edge; later changes are ignored.

Optional Feature:
- Macro: HS_ERR_CHK_EN.
- When defined:
  - proto_err sets if req is sampled 0 while state is ACK (master dropped req early).
  - It also sets if req rises while state is DROP.
  - It stays set until rst. Handshake behaviour is otherwise unchanged.
- When undefined: proto_err is constant 0 and no check logic is synthesised.

Decomposition:
- Shared package hs_pkg contains:
  - State enum hs_state_t (IDLE, ACK, HOLD, DROP, 2 bits).
  - Width helper constant CNT_W = 4 for the MIN_ACK counter.
- One sub-module, hs_sync_fifo (parameters DW, DEPTH), provides:
  - push and pop inputs, head data, count, full, empty.
- The top level holds the FSM, last_byte and proto_err.

Test Plan:
- Reset then single transfer, MIN_ACK=2:
  - Stimulus: req=1 with data_in=8'hA5; master drops req one cycle after ack rises.
  - Required: ack rises at the accepting edge and stays high 3 cycles; last_byte=8'hA5; count=1; rd_data=8'hA5; empty=0.
- Fill to full, DEPTH=4:
  - Stimulus: 4 transfers 8'h01..8'h04 with no reads, then a 5th req with 8'h05.
  - Required: full=1; ack stays 0 for the 5th req.
  - Then one rd_en (pops 8'h01); the 5th transfer is accepted at the following edge; FIFO contents are 02,03,04,05.
- Wrap-around:
  - Stimulus: 10 transfers 8'h10..8'h19, with one rd_en after each ack.
  - Required: popped sequence is 10..19 in order; count never exceeds 1; empty=1 at the end.
- Simultaneous push and pop:
  - Stimulus: count=2 and rd_en coincides with the accepting edge.
  - Required: count stays 2; head advances to the next word.
- Reset mid-handshake:
  - Stimulus: assert rst while in HOLD.
  - Required: ack=0, count=0, empty=1 and last_byte=0 after that edge.
  - With req still high after reset, a new word is accepted and count=1.
- HS_ERR_CHK_EN defined:
  - Stimulus: drop req during the first ACK cycle.
  - Required: proto_err=1 from the next edge and remains 1 until rst; ack still follows the MIN_ACK, HOLD, DROP sequence.
